// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the fifo block and the UART transmitter.
// master = transmitter (pops), slave = FIFO (supplies data and the empty flag).
interface fifo_uart_tx_if #(
   parameter int width = 4
);
   logic             empthy;
   logic [width-1:0] data_in;
   logic             read;

   modport master (input empthy, input data_in, output read);
   modport slave  (output empthy, output data_in, input read);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining asynchronous serial transmitter: pops one word per frame and
// sends start, data LSB-first, optional parity and stop bit(s) on tx.
module fifo_uart_tx #(
   parameter int width        = 4,
   parameter int clks_per_bit = 4,
   parameter int parity_en    = 1,
   parameter int parity_odd   = 0,
   parameter int stop_bits    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy
);

   localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   localparam int BW = $clog2(width + 1);

   localparam logic [CW-1:0] CYC_LAST  = CW'(clks_per_bit - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           r_state;
   logic [width-1:0] r_shreg;
   logic [CW-1:0]    r_cyc;
   logic [BW-1:0]    r_bit;
   logic             r_par;
   logic [width-1:0] w_shift;

   assign w_shift = r_shreg >> 1;

   // Outputs are assigned alongside each transition so tx/read/busy always
   // reflect the state being entered, not the one being left.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_cyc     <= '0;
         r_bit     <= '0;
         r_par     <= 1'b0;
         fifo.read <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else begin
         fifo.read <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!fifo.empthy) begin
                  r_state   <= POP;
                  fifo.read <= 1'b1;
                  busy      <= 1'b1;
               end
            end

            POP: begin
               r_state <= LOAD;
            end

            LOAD: begin
               r_shreg <= fifo.data_in;
               r_par   <= (^fifo.data_in) ^ (parity_odd != 0);
               r_cyc   <= '0;
               r_bit   <= '0;
               r_state <= START;
               tx      <= 1'b0;
            end

            START: begin
               if (r_cyc == CYC_LAST) begin
                  r_cyc   <= '0;
                  r_state <= DATA;
                  tx      <= r_shreg[0];
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end

            DATA: begin
               if (r_cyc == CYC_LAST) begin
                  r_cyc   <= '0;
                  r_shreg <= w_shift;
                  if (r_bit == BIT_LAST) begin
                     r_bit <= '0;
                     if (parity_en != 0) begin
                        r_state <= PARITY;
                        tx      <= r_par;
                     end else begin
                        r_state <= STOP;
                        tx      <= 1'b1;
                     end
                  end else begin
                     r_bit <= r_bit + 1'b1;
                     tx    <= w_shift[0];
                  end
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end

            PARITY: begin
               if (r_cyc == CYC_LAST) begin
                  r_cyc   <= '0;
                  r_state <= STOP;
                  tx      <= 1'b1;
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end

            STOP: begin
               // r_bit is reused here to count stop bits.
               if (r_cyc == CYC_LAST) begin
                  r_cyc <= '0;
                  if (r_bit == STOP_LAST) begin
                     r_bit <= '0;
                     if (!fifo.empthy) begin
                        r_state   <= POP;
                        fifo.read <= 1'b1;
                     end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                     end
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_cyc <= r_cyc + 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
               r_cyc   <= '0;
               r_bit   <= '0;
               tx      <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
